// File: rtl/module_bit_serial_adder.sv
// Bit-serial WIDTH-bit adder.
// One single-bit full adder is reused for WIDTH clock cycles, LSB first.
// The design has a valid/ready handshake on the operand side and another on
// the result side. It trades adder width for a WIDTH-cycle latency.

// Single-bit full adder, purely combinational.
module module_bit_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);

    logic half_sum_s;

    assign half_sum_s = a_i ^ b_i;
    assign sum_o      = half_sum_s ^ carry_i;
    assign carry_o    = (a_i & b_i) | (carry_i & half_sum_s);

endmodule

// Sequencer that walks the operands through the full adder one bit per cycle.
module module_bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    // The counter needs at least one bit, so WIDTH=1 still has a counter.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             out_valid_r;

    logic             accept_s;
    logic             last_s;
    logic             release_s;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic [WIDTH-1:0] sum_shift_s;

    // The same full adder serves every bit position. The carry flop closes the
    // ripple loop across cycles.
    module_bit_full_adder u_full_adder (
        .a_i     (a_sr_r[0]),
        .b_i     (b_sr_r[0]),
        .carry_i (carry_r),
        .sum_o   (fa_sum_s),
        .carry_o (fa_carry_s)
    );

    // Next value of the sum shift register.
    // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at
    // the LSB. Built without a part-select so that WIDTH=1 also works.
    always_comb begin
        sum_shift_s            = sum_sr_r >> 1;
        sum_shift_s[WIDTH-1]   = fa_sum_s;
    end

    // Next-state decode, plus the one-cycle event strobes used by the
    // datapath.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid_i) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    release_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register. Reset returns to IDLE and drops any operation in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand shift registers, carry flop and bit counter.
    // Operands are sampled only on the accept edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            a_sr_r   <= {WIDTH{1'b0}};
            b_sr_r   <= {WIDTH{1'b0}};
            sum_sr_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s) begin
            a_sr_r   <= a_i;
            b_sr_r   <= b_i;
            sum_sr_r <= {WIDTH{1'b0}};
            carry_r  <= carry_i;
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            a_sr_r   <= a_sr_r >> 1;
            b_sr_r   <= b_sr_r >> 1;
            sum_sr_r <= sum_shift_s;
            carry_r  <= fa_carry_s;
            cnt_r    <= cnt_r + CW'(1);
        end else begin
            a_sr_r   <= a_sr_r;
            b_sr_r   <= b_sr_r;
            sum_sr_r <= sum_sr_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

    // Result registers.
    // They load only on the last RUN edge and then hold until the next
    // operation completes, including while the block is IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (last_s) begin
            sum_r       <= sum_shift_s;
            carry_out_r <= fa_carry_s;
            out_valid_r <= 1'b1;
        end else if (release_s) begin
            sum_r       <= sum_r;
            carry_out_r <= carry_out_r;
            out_valid_r <= 1'b0;
        end else begin
            sum_r       <= sum_r;
            carry_out_r <= carry_out_r;
            out_valid_r <= out_valid_r;
        end
    end

    // The only path from an input to an output is through the reset term,
    // so the block never advertises readiness while reset is asserted.
    assign in_ready_o  = (state_r == IDLE) && rst_n_i;
    assign out_valid_o = out_valid_r;
    assign sum_o       = sum_r;
    assign carry_o     = carry_out_r;

endmodule

// File: tb/tb_module_bit_serial_adder.sv
// Directed and random checks of module_bit_serial_adder at WIDTH=8 and WIDTH=1.
// Expected results are queued on accept and popped when the result appears.
module tb_module_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       iv8, ir8, ov8, or8, c8, co8;
    logic [7:0] a8, b8, s8;

    logic       iv1, ir1, ov1, or1, c1, co1;
    logic [0:0] a1, b1, s1;

    logic       sel1;
    logic       obs_ready, obs_valid;
    logic [8:0] obs_res;

    logic [8:0] exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    module_bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv8), .in_ready_o(ir8),
        .a_i(a8), .b_i(b8), .carry_i(c8), .out_valid_o(ov8),
        .out_ready_i(or8), .sum_o(s8), .carry_o(co8)
    );

    module_bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv1), .in_ready_o(ir1),
        .a_i(a1), .b_i(b1), .carry_i(c1), .out_valid_o(ov1),
        .out_ready_i(or1), .sum_o(s1), .carry_o(co1)
    );

    // Select which instance the shared check tasks look at.
    always_comb begin
        if (sel1) begin
            obs_ready = ir1;
            obs_valid = ov1;
            obs_res   = {7'd0, co1, s1};
        end else begin
            obs_ready = ir8;
            obs_valid = ov8;
            obs_res   = {co8, s8};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
    endtask

    task automatic set_in_valid(input bit w1, input logic v);
        iv1 = w1 ? v : 1'b0;
        iv8 = w1 ? 1'b0 : v;
    endtask

    task automatic set_out_ready(input bit w1, input logic r);
        or1 = w1 ? r : 1'b0;
        or8 = w1 ? 1'b0 : r;
    endtask

    // One full operation: accept, latency/busy checks, optional stall, handshake.
    task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input int stall, input bit fatal_mode);
        logic [8:0] exp;
        logic [8:0] res_exp;
        int         w;
        bit         got;
        sel1 = w1;
        w    = w1 ? 1 : 8;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (obs_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("in_ready_wait", obs_ready, 1'b1);
        if (!got) return;

        if (w1) begin
            exp = {7'd0, 2'({1'b0, a[0]} + {1'b0, b[0]} + {1'b0, c})};
            a1 = a[0]; b1 = b[0]; c1 = c;
        end else begin
            exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
            a8 = a; b8 = b; c8 = c;
        end
        set_in_valid(w1, 1'b1);
        set_out_ready(w1, 1'b0);
        exp_q.push_back(exp);
        @(negedge clk);

        for (int k = 1; k <= w; k++) begin
            scramble();
            set_in_valid(w1, 1'($urandom));
            @(negedge clk);
            chk("busy_in_ready", obs_ready, 1'b0);
            chk("valid_latency", obs_valid, (k == w));
        end

        if (exp_q.size() == 0) begin
            chk("queue_underflow", 64'd0, 64'd1);
            return;
        end
        res_exp = exp_q.pop_front();
        n_assert++;
        assert (obs_res === res_exp) else begin
            n_fail++;
            $error("FAIL result observed=%0h expected=%0h", obs_res, res_exp);
            if (fatal_mode) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
                $fatal(1, "random vector diverged from model");
            end
        end

        for (int s = 0; s < stall; s++) begin
            set_in_valid(w1, 1'($urandom));
            scramble();
            @(negedge clk);
            chk("stall_valid", obs_valid, 1'b1);
            chk("stall_in_ready", obs_ready, 1'b0);
            chk("stall_result", obs_res, res_exp);
        end

        set_in_valid(w1, 1'b0);
        set_out_ready(w1, 1'b1);
        @(negedge clk);
        set_out_ready(w1, 1'b0);
        chk("post_hs_valid", obs_valid, 1'b0);
        chk("post_hs_in_ready", obs_ready, 1'b1);
        chk("post_hs_hold", obs_res, res_exp);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        sel1  = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_in_ready8", ir8, 1'b0);
        chk("rst_valid8", ov8, 1'b0);
        chk("rst_result8", {co8, s8}, 9'd0);
        chk("rst_in_ready1", ir1, 1'b0);
        chk("rst_result1", {ov1, co1, s1}, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready8", ir8, 1'b1);
        chk("idle_in_ready1", ir1, 1'b1);

        // Basic add and carry chain.
        run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        chk("basic_sum", {co8, s8}, 9'h096);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 0, 1'b0);
        chk("chain_ff_01", {co8, s8}, 9'h100);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 1, 1'b0);
        chk("chain_ff_ff_1", {co8, s8}, 9'h1FF);
        run_op(1'b0, 8'h00, 8'h00, 1'b1, 0, 1'b0);
        chk("chain_00_00_1", {co8, s8}, 9'h001);

        // Long backpressure with input toggling.
        run_op(1'b0, 8'h77, 8'h88, 1'b1, 10, 1'b0);
        chk("backpressure_sum", {co8, s8}, 9'h100);

        // Reset on the 4th RUN edge.
        sel1 = 1'b0;
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; iv8 = 1'b1;
        exp_q.push_back(9'h046);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("midrst_valid", ov8, 1'b0);
        chk("midrst_result", {co8, s8}, 9'h000);
        chk("midrst_in_ready", ir8, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_in_ready", ir8, 1'b1);
            chk("no_stale_valid", ov8, 1'b0);
        end
        run_op(1'b0, 8'h01, 8'h02, 1'b0, 0, 1'b0);
        chk("after_rst_sum", {co8, s8}, 9'h003);

        // Random vectors.
        for (int i = 0; i < 50; i++) begin
            run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/module_bit_serial_adder.md
# module_bit_serial_adder

Bit-serial WIDTH-bit adder built around one `module_bit_full_adder` instance plus a registered carry. It accepts two operands and a carry-in over a valid/ready handshake and feeds the full adder one bit pair per clock, LSB first. After WIDTH cycles it presents the WIDTH-bit sum and carry-out on a valid/ready output handshake. It is the sequencing stage directly upstream of the full adder and trades area for WIDTH-cycle latency.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1 to 64.
- `clk_i` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n_i` input, 1 bit: reset, synchronous and active-low.
- `in_valid_i` input, 1 bit: operands valid.
- `in_ready_o` output, 1 bit: block can accept operands.
- `a_i` input, WIDTH bits: operand A.
- `b_i` input, WIDTH bits: operand B.
- `carry_i` input, 1 bit: carry-in.
- `out_valid_o` output, 1 bit: result valid.
- `out_ready_i` input, 1 bit: downstream accepts the result.
- `sum_o` output, WIDTH bits: registered sum.
- `carry_o` output, 1 bit: registered carry-out.

## Operation
- FSM states:
  - IDLE: `in_ready_o`=1 and `out_valid_o`=0. On `in_valid_i`&&`in_ready_o`, capture `a_i`, `b_i` and `carry_i` into the A/B shift registers and the carry flop, clear the bit counter, and go to RUN.
  - RUN: each edge does the following:
    - Drive the full adder with A[0], B[0] and the carry flop.
    - Load the adder's `carry_o` into the carry flop.
    - Shift the adder's `sum_o` into the MSB of the sum shift register, and shift A and B right by one.
    - Increment the counter.
    - When the counter equals WIDTH-1, additionally load `sum_o`/`carry_o` from the final shifted value and adder carry, and go to DONE.
  - DONE: `out_valid_o`=1. `sum_o` and `carry_o` stay stable. On `out_ready_i`=1, go to IDLE.
- Result rule: {`carry_o`,`sum_o`} = `a_i` + `b_i` + `carry_i`, computed at (WIDTH+1)-bit width, with no truncation except to WIDTH+1 bits.
- Operands are sampled only on the accept edge. Changes to `a_i`, `b_i` or `carry_i` during RUN or DONE have no effect.
- `in_valid_i` is ignored outside IDLE; no operation is queued.
- `out_ready_i` is ignored outside DONE.
- `sum_o` and `carry_o` change only on the last RUN edge. They hold the last result through IDLE until the next operation completes.
- The counter is max(1,$clog2(WIDTH)) bits wide. WIDTH=1 means a single RUN edge.
- Reset: any edge with `rst_n_i`=0 forces IDLE and clears the shift registers, carry flop, counter, `sum_o`=0, `carry_o`=0 and `out_valid_o`=0. An in-flight operation is discarded without producing a result.
  - `in_ready_o` = (state==IDLE) && `rst_n_i`, so it is 0 while reset is asserted.

## Timing
- Accept at edge E0. Bit k is processed on edge E(k+1).
- `out_valid_o` rises on edge E(WIDTH), i.e. WIDTH edges after the accept edge.
- Result handshake at edge Ed leads to IDLE after Ed, with `in_ready_o`=1 in the following cycle.
- Minimum initiation interval is WIDTH+2 cycles, with zero output backpressure.
- No combinational path from inputs to outputs. The only input-dependent term is `in_ready_o`, which depends on `rst_n_i`.
- Backpressure: DONE holds indefinitely while `out_ready_i`=0. `in_ready_o` stays 0 for that whole time.

## Test plan
- WIDTH=8: a=0x5A, b=0x3C, c=0 → sum_o=0x96, carry_o=0. `out_valid_o` rises exactly 8 edges after accept, and `in_ready_o` is 0 for cycles 1 to 9.
- Carry chain: 0xFF+0x01+0 → sum_o=0x00, carry_o=1. Also 0xFF+0xFF+1 → sum_o=0xFF, carry_o=1, and 0x00+0x00+1 → sum_o=0x01, carry_o=0.
- Backpressure: hold `out_ready_i`=0 for 10 cycles in DONE while toggling `in_valid_i` and `a_i`.
  - Required: `sum_o`, `carry_o` and `out_valid_o`=1 stay stable and `in_ready_o`=0.
  - On release, exactly one handshake occurs, then IDLE.
- Reset mid-RUN: start 0x12+0x34 and drive `rst_n_i`=0 on the 4th RUN edge.
  - Required: next cycle shows `out_valid_o`=0 and `sum_o`=0x00.
  - After release, `in_ready_o`=1 and no stale result ever appears.
  - A subsequent 0x01+0x02+0 gives 0x03.
- Input stability: change `a_i`/`b_i` every cycle during RUN. The result must match the operands sampled at accept only.
- Random: 50 vectors with WIDTH=8 plus 10 vectors with WIDTH=1. Compare against {c,s}=a+b+cin with random `out_ready_i` stalls, and use $fatal on mismatch.
